// File: rtl/io_bus_master.sv
// Command-driven IO bus master: writes two output registers and performs a
// ready/valid handshake to capture a switch input. Optional poll timeout: IOBM_TIMEOUT_EN.
module io_bus_master #(
    parameter int IN_WIDTH       = 5,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [7:0]  io_addr,
    output logic [31:0] io_dout,
    output logic        io_we,
    input  logic [31:0] io_din
);

    typedef enum logic [2:0] {
        IDLE, WR, RDY_SET, POLL_V, RD_IN, RDY_CLR, WAIT_VL
    } state_t;

    state_t      state_reg, state_next;
    logic        wr_sel_reg;
    logic [31:0] data_reg;
    logic        done_reg, done_next;
    logic [31:0] rdata_reg;
    logic        timeout;

    if (IN_WIDTH < 1 || IN_WIDTH > 32) begin : g_bad_in_width
        $error("IN_WIDTH must be in 1..32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Bits of io_din above the switch field are never looked at.
    if (IN_WIDTH < 32) begin : g_unused_din
        logic unused_din;
        assign unused_din = &{1'b0, io_din[31:IN_WIDTH]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            wr_sel_reg <= 1'b0;
            data_reg   <= '0;
            done_reg   <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (state_reg == IDLE && req) begin
                wr_sel_reg <= req_op[0];
                data_reg   <= req_data;
            end
            if (state_reg == RD_IN)
                rdata_reg <= 32'(io_din[IN_WIDTH-1:0]);
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        io_addr    = 8'h00;
        io_we      = 1'b0;
        io_dout    = '0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    case (req_op)
                        2'b00, 2'b01: state_next = WR;
                        2'b10:        state_next = RDY_SET;
                        default:      state_next = IDLE;
                    endcase
                end
            end
            WR: begin
                io_we      = 1'b1;
                io_addr    = wr_sel_reg ? 8'h08 : 8'h00;
                io_dout    = data_reg;
                state_next = IDLE;
                done_next  = 1'b1;
            end
            RDY_SET: begin
                io_we      = 1'b1;
                io_addr    = 8'h04;
                io_dout    = 32'd1;
                state_next = POLL_V;
            end
            POLL_V: begin
                io_addr = 8'h10;
                if (io_din[0])
                    state_next = RD_IN;
                else if (timeout)
                    state_next = RDY_CLR;
            end
            RD_IN: begin
                io_addr    = 8'h0C;
                state_next = RDY_CLR;
            end
            RDY_CLR: begin
                io_we      = 1'b1;
                io_addr    = 8'h04;
                state_next = WAIT_VL;
            end
            WAIT_VL: begin
                io_addr = 8'h10;
                if (!io_din[0] || timeout) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef IOBM_TIMEOUT_EN
    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             to_reg;
    logic             err_reg;

    // Counter runs only while dwelling in a poll state; any transition clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_reg <= '0;
        else if ((state_reg == POLL_V || state_reg == WAIT_VL) && state_next == state_reg)
            cnt_reg <= cnt_reg + CNT_W'(1);
        else
            cnt_reg <= '0;
    end

    assign timeout = (cnt_reg == CNT_LAST);

    // to_reg remembers a POLL_V timeout so err lines up with the eventual done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_reg  <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            err_reg <= done_next && (to_reg || (state_reg == WAIT_VL && io_din[0]));
            if (state_reg == IDLE)
                to_reg <= 1'b0;
            else if (state_reg == POLL_V && !io_din[0] && timeout)
                to_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_io_bus_master.sv
// Table-driven bench for io_bus_master with a behavioural IO responder and a
// queue of expected bus writes checked as the master issues them.
module tb_io_bus_master;

    localparam int IN_WIDTH = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_data = '0;
    logic        busy, done, err, io_we;
    logic [31:0] rdata, io_dout, io_din;
    logic [7:0]  io_addr;

    io_bus_master #(.IN_WIDTH(IN_WIDTH), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_data(req_data),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_din(io_din)
    );

    always #5 clk = ~clk;

    // Responder: valid rises rise_dly cycles after ready is set, falls
    // fall_dly cycles after ready is cleared.
    logic [31:0] out0, out1;
    logic [31:0] in_val = '0;
    logic        rdy, valid;
    int          rise_cnt, fall_cnt;
    int          rise_dly = 0, fall_dly = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            out0 <= '0; out1 <= '0; rdy <= 1'b0;
            rise_cnt <= 0; fall_cnt <= 1000000;
        end else begin
            if (rise_cnt < 1000000) rise_cnt <= rise_cnt + 1;
            if (fall_cnt < 1000000) fall_cnt <= fall_cnt + 1;
            if (io_we) begin
                case (io_addr)
                    8'h00: out0 <= io_dout;
                    8'h08: out1 <= io_dout;
                    8'h04: begin
                        rdy <= io_dout[0];
                        if (io_dout[0]) rise_cnt <= 0;
                        else            fall_cnt <= 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb valid = rdy ? (rise_cnt >= rise_dly) : (fall_cnt < fall_dly);

    always_comb begin
        case (io_addr)
            8'h00:   io_din = out0;
            8'h04:   io_din = {31'b0, rdy};
            8'h08:   io_din = out1;
            8'h0C:   io_din = in_val;
            8'h10:   io_din = {31'b0, valid};
            default: io_din = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        int          rise;
        int          fall;
        logic [31:0] in_val;
        int          exp_busy;
        int          exp_done;
        int          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[8];
    int   n_cmp = 0, n_fail = 0;
    int   cyc = 0, busy_cnt = 0, done_cnt = 0, err_cnt = 0, wr_cnt = 0;
    int   last_busy_cyc = 0, done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, score any bus write.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc++;
        if (busy) begin busy_cnt++; last_busy_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) begin
            err_cnt++;
            chk("err_with_done", {31'b0, done}, 32'd1);
        end
        if (!rst && io_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h, expected no write",
                         io_addr, io_dout);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {24'b0, io_addr}, {24'b0, e.addr});
                chk("wr_data", io_dout, e.data);
            end
        end
    endtask

    task automatic push_expected(input logic [1:0] op, input logic [31:0] data);
        case (op)
            2'b00: exp_q.push_back('{8'h00, data});
            2'b01: exp_q.push_back('{8'h08, data});
            2'b10: begin
                exp_q.push_back('{8'h04, 32'd1});
                exp_q.push_back('{8'h04, 32'd0});
            end
            default: ;
        endcase
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int b0, d0, e0, n;
        b0 = busy_cnt; d0 = done_cnt; e0 = err_cnt;
        push_expected(v.op, v.data);
        rise_dly = v.rise; fall_dly = v.fall; in_val = v.in_val;
        req = 1'b1; req_op = v.op; req_data = v.data;
        tick();
        req = 1'b0;
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        if (n >= 400) begin
            n_cmp++; n_fail++;
            $display("FAIL vec%0d_stuck_busy: got busy after 400 cycles, expected idle", idx);
        end
        tick(); tick();
        chk($sformatf("vec%0d_busy_cycles", idx), 32'(busy_cnt - b0), 32'(v.exp_busy));
        chk($sformatf("vec%0d_done_count", idx), 32'(done_cnt - d0), 32'(v.exp_done));
        chk($sformatf("vec%0d_err_count", idx), 32'(err_cnt - e0), 32'(v.exp_err));
        chk($sformatf("vec%0d_rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("vec%0d_writes_left", idx), 32'(exp_q.size()), 32'd0);
        chk($sformatf("vec%0d_idle_bus", idx), {io_we, io_addr, io_dout[22:0]}, 32'd0);
        if (v.exp_done != 0)
            chk($sformatf("vec%0d_done_latency", idx), 32'(done_cyc), 32'(last_busy_cyc + 1));
        exp_q.delete();
        $display("vec%0d op=%0d data=%08h busy=%0d done=%0d err=%0d rdata=%08h",
                 idx, v.op, v.data, busy_cnt - b0, done_cnt - d0, err_cnt - e0, rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench hung");
    end

    initial begin
        int   d0, w0;
        vec_t tv;
        vecs[0] = '{2'b01, 32'h1234_5678, 0, 0, 32'h0,         1, 1, 0, 32'h0000_0000};
        vecs[1] = '{2'b10, 32'h0,         2, 2, 32'hABCD_EF15, 9, 1, 0, 32'h0000_0015};
        vecs[2] = '{2'b11, 32'h0000_DEAD, 0, 0, 32'h0,         0, 0, 0, 32'h0000_0015};
        vecs[3] = '{2'b00, 32'hCAFE_F00D, 0, 0, 32'h0,         1, 1, 0, 32'h0000_0015};
        vecs[4] = '{2'b10, 32'h0,         0, 0, 32'h0000_000A, 5, 1, 0, 32'h0000_000A};
        vecs[5] = '{2'b10, 32'h0,         5, 1, 32'hFFFF_FFE0, 11, 1, 0, 32'h0000_0000};
        vecs[6] = '{2'b01, 32'h0000_0000, 0, 0, 32'h0,         1, 1, 0, 32'h0000_0000};
        vecs[7] = '{2'b10, 32'h0,         1, 3, 32'h0000_001F, 9, 1, 0, 32'h0000_001F};

        tick(); tick();
        chk("reset_outputs", {28'b0, busy, done, err, io_we}, 32'd0);
        chk("reset_addr", {24'b0, io_addr}, 32'd0);
        chk("reset_dout", io_dout, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
        chk("out1_after_writes", out1, 32'h0000_0000);
        chk("out0_after_writes", out0, 32'hCAFE_F00D);

`ifdef IOBM_TIMEOUT_EN
        tv = '{2'b10, 32'h0, 100000, 0, 32'h0000_001B, 11, 1, 1, 32'h0000_001F};
        run_vec(8, tv);
        rise_dly = 0;
`endif

        // req held high: the second write is accepted in the done cycle.
        push_expected(2'b00, 32'h1111_AAAA);
        push_expected(2'b00, 32'h2222_BBBB);
        d0 = done_cnt; w0 = wr_cnt;
        req = 1'b1; req_op = 2'b00; req_data = 32'h1111_AAAA;
        tick();
        req_data = 32'h2222_BBBB;
        tick();
        chk("b2b_done_in_gap", {31'b0, done}, 32'd1);
        chk("b2b_idle_in_gap", {31'b0, busy}, 32'd0);
        tick();
        req = 1'b0;
        tick(); tick();
        chk("b2b_write_count", 32'(wr_cnt - w0), 32'd2);
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        chk("b2b_writes_left", 32'(exp_q.size()), 32'd0);
        chk("b2b_out0", out0, 32'h2222_BBBB);
        exp_q.delete();
        $display("b2b writes=%0d dones=%0d out0=%08h", wr_cnt - w0, done_cnt - d0, out0);

        // Reset while polling for valid.
        push_expected(2'b10, 32'h0);
        rise_dly = 100000; in_val = 32'h0000_0003;
        req = 1'b1; req_op = 2'b10; req_data = 32'h0;
        tick();
        req = 1'b0;
        tick(); tick();
        chk("poll_before_reset", {24'b0, io_addr}, 32'h0000_0010);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {28'b0, busy, done, err, io_we}, 32'd0);
        chk("rst_mid_addr", {24'b0, io_addr}, 32'd0);
        chk("rst_mid_dout", io_dout, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        exp_q.delete();
        d0 = done_cnt;
        tick();
        rst = 1'b0;
        rise_dly = 0;
        tick(); tick(); tick(); tick();
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_mid_idle", {31'b0, busy}, 32'd0);
        $display("reset-in-poll done=%0d busy=%0d rdata=%08h", done_cnt - d0, busy, rdata);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 5: width of the switch input field captured from address 0x0C.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: poll limit, used only when IOBM_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk  input  1: clock, all state updated on posedge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  1: command request, sampled only when busy=0.
REQ-006 SHALL have port req_op  input  2: command, 00 = write out0, 01 = write out1, 10 = get input, 11 = reserved.
REQ-007 SHALL have port req_data  input  32: write data for ops 00/01.
REQ-008 SHALL have port busy  output  1: high whenever the FSM is not IDLE.
REQ-009 SHALL have port done  output  1: one-cycle completion pulse.
REQ-010 SHALL have port err  output  1: one-cycle timeout pulse, coincident with done.
REQ-011 SHALL have port rdata  output  32: last captured input, zero-extended from IN_WIDTH.
REQ-012 SHALL have port io_addr  output  8: IO bus address.
REQ-013 SHALL have port io_dout  output  32: IO bus write data.
REQ-014 SHALL have port io_we  output  1: IO bus write strobe, one cycle per write.
REQ-015 SHALL have port io_din  input  32: IO bus read data, combinational from io_addr in the responder.

Function
REQ-016 SHALL implement states IDLE, WR, RDY_SET, POLL_V, RD_IN, RDY_CLR, WAIT_VL.
REQ-017 SHALL, in IDLE, drive io_addr=0x00, io_we=0, io_dout=0.
REQ-018 SHALL, in IDLE with req=1: latch req_op/req_data; ops 00/01 -> WR, op 10 -> RDY_SET, op 11 -> stay IDLE with no done and no bus activity.
REQ-019 SHALL ignore req while busy=1 (no queueing).
REQ-020 SHALL, in WR, drive io_we=1, io_addr=0x00 (op 00) or 0x08 (op 01), io_dout=latched data, then go to IDLE.
REQ-021 SHALL, in RDY_SET, drive io_we=1, io_addr=0x04, io_dout=1, then go to POLL_V.
REQ-022 SHALL, in POLL_V, drive io_addr=0x10, io_we=0; go to RD_IN when io_din[0]=1, else stay.
REQ-023 SHALL, in RD_IN, drive io_addr=0x0C, io_we=0, load rdata with io_din[IN_WIDTH-1:0] zero-extended at the clock edge, then go to RDY_CLR.
REQ-024 SHALL, in RDY_CLR, drive io_we=1, io_addr=0x04, io_dout=0, then go to WAIT_VL.
REQ-025 SHALL, in WAIT_VL, drive io_addr=0x10, io_we=0; go to IDLE when io_din[0]=0, else stay.
REQ-026 SHALL register done: high for exactly the first IDLE cycle after WR, or after WAIT_VL exit.
REQ-027 SHALL accept a new req in the same cycle that done is high.
REQ-028 Write latency SHALL be: req sampled at edge N, io_we in cycle N+1, done in cycle N+2.
REQ-029 Input latency SHALL be minimum 5 busy cycles (valid already 1, then 0 immediately); done follows the last busy cycle.
REQ-030 rdata SHALL change only in RD_IN and SHALL hold between operations.

Reset
REQ-031 SHALL, on rst, immediately force state IDLE, busy=0, done=0, err=0, rdata=0, io_we=0, io_addr=0x00, io_dout=0, and clear the timeout counter.
REQ-032 SHALL, on rst asserted mid-operation, abandon the operation with no done pulse; the responder's ready level is restored by the responder's own reset.

Configuration
REQ-033 Macro IOBM_TIMEOUT_EN defined: a counter SHALL clear on entering POLL_V/WAIT_VL and increment each cycle there; at TIMEOUT_CYCLES, POLL_V SHALL go to RDY_CLR (rdata unchanged) and WAIT_VL SHALL go to IDLE, and err SHALL pulse with the resulting done.
REQ-034 Macro IOBM_TIMEOUT_EN undefined: POLL_V/WAIT_VL SHALL wait indefinitely, no counter logic, err tied 0.

Verification
REQ-035 Reset then req op=01, data 0x1234_5678 -> one cycle io_we=1, io_addr=0x08, io_dout=0x1234_5678; done next cycle; busy exactly 1 cycle.
REQ-036 req op=10, responder valid rises 3 cycles after RDY_SET, in=5'h15, valid falls 2 cycles after RDY_CLR -> write 0x04<-1, poll 0x10, read 0x0C, rdata=0x0000_0015, write 0x04<-0, done once.
REQ-037 req held high through an op=00 command -> second command starts in the done cycle, no write lost or duplicated.
REQ-038 req op=11 -> no io_we, busy stays 0, no done.
REQ-039 rst asserted during POLL_V -> outputs at reset values that cycle, no done, rdata=0.
REQ-040 With IOBM_TIMEOUT_EN, TIMEOUT_CYCLES=8, valid held 0 -> 8 POLL_V cycles, RDY_CLR write 0x04<-0, done and err pulse together, rdata unchanged.
